// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage.
// Generates sequential word addresses and fetches from instruction memory over
// a req/ack handshake with at most one transaction outstanding. Fetched words
// and their PCs are buffered in a circular prefetch queue. The queue head is
// presented to decode with valid/ready. A redirect flushes the queue and
// restarts fetch at the new target.
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,            // power of two, >= 2
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        r_state;
    logic          r_req;
    logic [31:0]   r_addr;
    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [31:0]   r_data [DEPTH];
    logic [31:0]   r_pc   [DEPTH];

    logic          w_ack;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_next;
    logic [31:0]   w_redirect_pc;
    logic [31:0]   w_addr_inc;

    // Handshake completes only while a request is actually outstanding.
    assign w_ack         = r_req && imem_ack;
    // Data returned in DROP, or in the cycle of a redirect, is stale and discarded.
    assign w_push        = (r_state == WAIT) && w_ack && !redirect;
    // A redirect flushes the queue, so a pop in the same cycle is meaningless.
    assign w_pop         = instr_valid && instr_ready && !redirect;
    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_addr_inc    = r_addr + 32'd4;

    // Occupancy after this cycle; IDLE/WAIT use it to reserve a slot before requesting.
    always_comb begin
        w_count_next = r_count;
        if (redirect) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // Queue storage: data path only, contents are qualified by r_count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_data[r_wr_ptr] <= imem_rdata;
            r_pc[r_wr_ptr]   <= r_addr;
        end
    end

    // Queue control: occupancy and wrapping pointers, cleared by reset or redirect.
    always_ff @(posedge clock) begin
        if (reset || redirect) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Fetch FSM: issues requests, tracks the fetch PC and drains stale transactions.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
        end else begin
            if (redirect) r_fetch_pc <= w_redirect_pc;
            case (r_state)
                IDLE: begin
                    // On redirect the request waits one cycle for the empty queue.
                    if (!redirect && (w_count_next < FULL)) begin
                        r_state <= WAIT;
                        r_req   <= 1'b1;
                        r_addr  <= r_fetch_pc;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        // The handshake cannot be aborted: finish it in DROP.
                        if (w_ack) begin
                            r_state <= IDLE;
                            r_req   <= 1'b0;
                        end else begin
                            r_state <= DROP;
                        end
                    end else if (w_ack) begin
                        r_fetch_pc <= w_addr_inc;
                        if (w_count_next < FULL) begin
                            r_addr <= w_addr_inc;
                        end else begin
                            r_state <= IDLE;
                            r_req   <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (w_ack) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instr_valid = (r_count != '0);
    assign instr       = instr_valid ? r_data[r_rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? r_pc[r_rd_ptr]   : 32'h0;

endmodule
